vec_mul_sequencer: RTL and testbench

- Control sequencer for the 1x64 vector-multiply datapath: Unified Buffer SRAM, Weight FIFO, vec_mul array and Results SRAM.
- On a start command, it optionally pops one weight tile from the FIFO and pulses weight_reload. It then streams a programmable run of input vectors from the Unified Buffer.
- It generates result-SRAM write strobes and addresses aligned to the datapath latency, then signals completion.
- Replaces ad-hoc valid_address/counter gluing at the top level.

---
 rtl/vec_mul_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_vec_mul_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mul_sequencer.sv
// Control sequencer for the 1x64 vector-multiply datapath: weight fetch/reload,
// Unified Buffer read issue, latency-aligned Results SRAM writes and completion.
module vec_mul_sequencer #(
  parameter int ADDRESSSIZE  = 10,
  parameter int SRAM_RD_LAT  = 1,
  parameter int PIPE_LATENCY = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   load_weights,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  input  logic [ADDRESSSIZE:0]   num_vectors,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   weight_reload,
  output logic [ADDRESSSIZE-1:0] sram_address,
  output logic                   valid_address,
  output logic                   result_write_enable,
  output logic [ADDRESSSIZE-1:0] result_address,
  output logic                   busy,
  output logic                   done
);

  localparam int LAT = SRAM_RD_LAT + PIPE_LATENCY;
  localparam int AW  = ADDRESSSIZE;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WFETCH  = 3'd1,
    S_WRELOAD = 3'd2,
    S_STREAM  = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [AW:0]     n_q, n_d;
  logic [AW:0]     k_q, k_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [LAT-2:0]  sr_q, sr_d;

  logic            fre_q, fre_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            valid_q, valid_d;
  logic            rwe_q, rwe_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            abort_s;

  assign abort_s = abort && (state_q != S_IDLE);

  // Next-state, operand capture and registered-output computation.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    n_d     = n_q;
    k_d     = k_q;
    fre_d   = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d = src_base;
          dst_d = dst_base;
          n_d   = num_vectors;
          k_d   = '0;
          if (load_weights) begin
            state_d = S_WFETCH;
            fre_d   = !fifo_empty;
          end else if (num_vectors == '0) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_STREAM;
            valid_d = 1'b1;
            addr_d  = src_base;
            k_d     = {{AW{1'b0}}, 1'b1};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      // A pop visible this cycle means the tile is on the FIFO output next.
      S_WFETCH: begin
        if (fre_q) begin
          state_d = S_WRELOAD;
          wr_d    = 1'b1;
        end else if (!fifo_empty) begin
          fre_d = 1'b1;
        end else begin
          state_d = S_WFETCH;
        end
      end
      S_WRELOAD: begin
        if (n_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_STREAM;
          valid_d = 1'b1;
          addr_d  = src_q;
          k_d     = {{AW{1'b0}}, 1'b1};
        end
      end
      S_STREAM: begin
        if (k_q == n_q) begin
          state_d = S_DRAIN;
        end else begin
          valid_d = 1'b1;
          addr_d  = src_q + k_q[AW-1:0];
          k_d     = k_q + {{AW{1'b0}}, 1'b1};
        end
      end
      S_DRAIN: begin
        if (sr_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_s) begin
      state_d = S_IDLE;
      fre_d   = 1'b0;
      wr_d    = 1'b0;
      valid_d = 1'b0;
      addr_d  = '0;
      k_d     = '0;
    end else begin
      k_d = k_d;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Result alignment: issues ripple through LAT-1 stages, then the write register.
  always_comb begin
    sr_d    = '0;
    rwe_d   = 1'b0;
    wcnt_d  = '0;
    raddr_d = '0;
    if (abort_s) begin
      sr_d   = '0;
      rwe_d  = 1'b0;
      wcnt_d = '0;
    end else begin
      sr_d  = {sr_q[LAT-3:0], valid_q};
      rwe_d = sr_q[LAT-2];
      if (state_q == S_IDLE && start) begin
        wcnt_d = '0;
      end else begin
        wcnt_d = wcnt_q + {{(AW-1){1'b0}}, rwe_d};
      end
    end
    if (rwe_d) begin
      raddr_d = dst_q + wcnt_q;
    end else begin
      raddr_d = '0;
    end
  end

  // State, operand and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      wcnt_q  <= '0;
      sr_q    <= '0;
      fre_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      rwe_q   <= 1'b0;
      raddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      n_q     <= n_d;
      k_q     <= k_d;
      wcnt_q  <= wcnt_d;
      sr_q    <= sr_d;
      fre_q   <= fre_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      rwe_q   <= rwe_d;
      raddr_q <= raddr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_read_enable    = fre_q;
  assign weight_reload       = wr_q;
  assign sram_address        = addr_q;
  assign valid_address       = valid_q;
  assign result_write_enable = rwe_q;
  assign result_address      = raddr_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Self-checking bench for vec_mul_sequencer: per-cycle comparison of every output
// against a timeline model derived from the command parameters.
module tb_vec_mul_sequencer;

  localparam int AW  = 10;
  localparam int LAT = 65;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          load_weights;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [AW:0]   num_vectors;
  logic          fifo_empty;
  logic          fifo_read_enable;
  logic          weight_reload;
  logic [AW-1:0] sram_address;
  logic          valid_address;
  logic          result_write_enable;
  logic [AW-1:0] result_address;
  logic          busy;
  logic          done;
  logic [25:0]   obs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vec_mul_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .abort               (abort),
    .load_weights        (load_weights),
    .src_base            (src_base),
    .dst_base            (dst_base),
    .num_vectors         (num_vectors),
    .fifo_empty          (fifo_empty),
    .fifo_read_enable    (fifo_read_enable),
    .weight_reload       (weight_reload),
    .sram_address        (sram_address),
    .valid_address       (valid_address),
    .result_write_enable (result_write_enable),
    .result_address      (result_address),
    .busy                (busy),
    .done                (done)
  );

  assign obs = {fifo_read_enable, weight_reload, valid_address, sram_address,
                result_write_enable, result_address, busy, done};

  // Cycle t counts from the start edge (t=1 is the first cycle after it).
  // With a weight load, fifo_empty is 1 for cycles 0..stall-1.
  function automatic int done_cycle(bit load, int n, int stall);
    int t0;
    t0 = load ? stall + 3 : 1;
    return (n == 0) ? t0 + 1 : t0 + n + LAT;
  endfunction

  function automatic logic [25:0] model(int t, bit load, int src, int dst, int n, int stall);
    int t0, p, dn;
    logic fre, wr, vld, rwe, bsy, dne;
    logic [AW-1:0] a, ra;
    p   = stall + 1;
    t0  = load ? stall + 3 : 1;
    dn  = done_cycle(load, n, stall);
    fre = load && (t == p);
    wr  = load && (t == p + 1);
    vld = (n > 0) && (t >= t0) && (t < t0 + n);
    a   = vld ? AW'(src + t - t0) : '0;
    rwe = (n > 0) && (t >= t0 + LAT) && (t < t0 + LAT + n);
    ra  = rwe ? AW'(dst + t - t0 - LAT) : '0;
    bsy = (t >= 1) && (t <= dn);
    dne = (t == dn);
    return {fre, wr, vld, a, rwe, ra, bsy, dne};
  endfunction

  task automatic test_command(input string name, input bit load, input int src, input int dst,
                              input int n, input int stall, input bit noise);
    int dn;
    logic [25:0] e;
    dn = done_cycle(load, n, stall);
    @(posedge clk); #1;
    start        = 1'b1;
    load_weights = load;
    src_base     = AW'(src);
    dst_base     = AW'(dst);
    num_vectors  = (AW+1)'(n);
    fifo_empty   = (stall > 0);
    @(posedge clk);
    for (int t = 1; t <= dn + 2; t++) begin
      #1;
      e = model(t, load, src, dst, n, stall);
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, t, obs, e);
      end
      fifo_empty = (t < stall);
      if (noise && t <= dn) begin
        start        = 1'($urandom_range(0, 1));
        load_weights = 1'($urandom_range(0, 1));
        src_base     = AW'($urandom);
        dst_base     = AW'($urandom);
        num_vectors  = (AW+1)'($urandom_range(0, 1024));
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
    end
    start      = 1'b0;
    fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1; abort = 1'b0; load_weights = 1'b1;
    src_base = 10'd5; dst_base = 10'd6; num_vectors = 11'd3; fifo_empty = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if (obs !== 26'd0) begin
        fails++;
        $display("FAIL reset_hold: got %h expected %h", obs, 26'd0);
      end
    end
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      tests++;
      if (obs !== 26'd0) begin
        fails++;
        $display("FAIL reset_release: got %h expected %h", obs, 26'd0);
      end
    end
  endtask

  task automatic test_abort();
    logic [25:0] e;
    @(posedge clk); #1;
    start = 1'b1; load_weights = 1'b0; src_base = 10'd100; dst_base = 10'd200;
    num_vectors = 11'd8; fifo_empty = 1'b0;
    @(posedge clk);
    for (int t = 1; t <= 2; t++) begin
      #1;
      start = 1'b0;
      e = model(t, 1'b0, 100, 200, 8, 0);
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL abort_pre cycle %0d: got %h expected %h", t, obs, e);
      end
      abort = (t == 2);
      @(posedge clk);
    end
    #1 abort = 1'b0;
    for (int t = 3; t < 90; t++) begin
      tests++;
      if (obs !== 26'd0) begin
        fails++;
        $display("FAIL abort_quiet cycle %0d: got %h expected %h", t, obs, 26'd0);
      end
      @(posedge clk); #1;
    end
    test_command("after_abort", 1'b1, 300, 400, 5, 2, 1'b0);
  endtask

  task automatic test_rst_drain();
    logic [25:0] e;
    @(posedge clk); #1;
    start = 1'b1; load_weights = 1'b0; src_base = 10'd7; dst_base = 10'd9;
    num_vectors = 11'd2; fifo_empty = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    e = model(20, 1'b0, 7, 9, 2, 0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL rst_drain_pre: got %h expected %h", obs, e);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (obs !== 26'd0) begin
      fails++;
      $display("FAIL rst_drain_async: got %h expected %h", obs, 26'd0);
    end
    @(negedge clk); rst = 1'b0;
    for (int t = 0; t < 80; t++) begin
      @(posedge clk); #1;
      tests++;
      if (obs !== 26'd0) begin
        fails++;
        $display("FAIL rst_drain_quiet cycle %0d: got %h expected %h", t, obs, 26'd0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_command("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 1023)), int'($urandom_range(0, 20)),
                   int'($urandom_range(0, 5)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_command("basic", 1'b0, 0, 0, 4, 0, 1'b0);
    test_command("stall", 1'b1, 5, 9, 3, 10, 1'b0);
    test_command("wrap", 1'b0, 1022, 1023, 3, 0, 1'b0);
    test_command("zero_load", 1'b1, 17, 33, 0, 0, 1'b0);
    test_command("zero_noload", 1'b0, 17, 33, 0, 0, 1'b0);
    test_abort();
    test_command("busy_start", 1'b0, 50, 60, 6, 0, 1'b1);
    test_rst_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
